// File: rtl/input_mode_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : input_mode_sequencer_pkg
//  Description : Shared game-mode encodings and default frame constants for
//                the input/mode sequencer and related game logic.
//  Revision    : 1.0 - initial release
// ============================================================================
package input_mode_sequencer_pkg;

    // Top-level game mode, as exported on game_state
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PLAY    = 2'd1,
        ST_DEAD    = 2'd2,
        ST_ATTRACT = 2'd3
    } game_state_t;

    // Default frame constants
    localparam int c_idle_frames      = 600;
    localparam int c_dead_lock_frames = 30;
    localparam int c_restart_frames   = 60;
    localparam int c_cnt_w            = 10;

endpackage : input_mode_sequencer_pkg
`default_nettype wire

// File: rtl/input_mode_sequencer_frame_counter.sv
`default_nettype none
// ============================================================================
//  Module      : frame_counter
//  Description : Saturating up-counter with a tick enable and a synchronous
//                clear. Clear has priority over the tick.
//  Revision    : 1.0 - initial release
// ============================================================================
module frame_counter #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_tick,
    input  logic             i_clear,
    output logic [WIDTH-1:0] o_count
);

    localparam logic [WIDTH-1:0] c_max = {WIDTH{1'b1}};

    logic [WIDTH-1:0] r_count;

    // Count ticks, hold at all-ones, clear on request
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_tick && (r_count != c_max)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule : frame_counter
`default_nettype wire

// File: rtl/input_mode_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : input_mode_sequencer
//  Description : Arbitrates jump/duck between buttons, gamepad and autopilot,
//                and sequences the game through IDLE, PLAY, DEAD and ATTRACT,
//                issuing one-cycle restart pulses to the game logic.
//  Revision    : 1.0 - initial release
// ============================================================================
module input_mode_sequencer
    import input_mode_sequencer_pkg::*;
#(
    parameter int IDLE_FRAMES      = c_idle_frames,
    parameter int DEAD_LOCK_FRAMES = c_dead_lock_frames,
    parameter int RESTART_FRAMES   = c_restart_frames,
    parameter int CNT_W            = c_cnt_w
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       gamepad_is_present,
    input  logic       gamepad_up,
    input  logic       gamepad_down,
    input  logic       ai_up,
    input  logic       crash,
    output logic       jump_out,
    output logic       duck_out,
    output logic       restart_pulse,
    output logic       autopilot,
    output logic [1:0] game_state
);

    localparam logic [CNT_W-1:0] c_idle_lim    = CNT_W'(IDLE_FRAMES);
    localparam logic [CNT_W-1:0] c_lock_lim    = CNT_W'(DEAD_LOCK_FRAMES);
    localparam logic [CNT_W-1:0] c_restart_lim = CNT_W'(RESTART_FRAMES);

    game_state_t      r_state;
    game_state_t      w_state_nxt;
    logic             r_h_up_prev;
    logic             r_jump;
    logic             r_duck;
    logic             r_restart;
    logic             r_autopilot;

    logic             w_h_up;
    logic             w_h_dn;
    logic             w_h_act;
    logic             w_h_edge;
    logic             w_jump_nxt;
    logic             w_duck_nxt;
    logic             w_restart_req;
    logic             w_restart_nxt;
    logic             w_cnt_rearm;
    logic             w_cnt_clear;
    logic [CNT_W-1:0] w_cnt;

    // Human input merge: the gamepad only counts while it is attached
    assign w_h_up   = btn_up   | (gamepad_is_present & gamepad_up);
    assign w_h_dn   = btn_down | (gamepad_is_present & gamepad_down);
    assign w_h_act  = w_h_up | w_h_dn;
    assign w_h_edge = w_h_up & ~r_h_up_prev;

    frame_counter #(
        .WIDTH (CNT_W)
    ) u_frame_counter (
        .clk     (clk),
        .rst     (rst),
        .i_tick  (frame_tick),
        .i_clear (w_cnt_clear),
        .o_count (w_cnt)
    );

    // Next-state, arbitrated controls and restart request
    always_comb begin
        w_state_nxt   = r_state;
        w_jump_nxt    = 1'b0;
        w_duck_nxt    = 1'b0;
        w_restart_req = 1'b0;
        w_cnt_rearm   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_jump_nxt = w_h_up;
                w_duck_nxt = w_h_dn & ~w_h_up;
                if (w_h_edge) begin
                    w_state_nxt   = ST_PLAY;
                    w_restart_req = 1'b1;
                end else if (!w_h_act && (w_cnt >= c_idle_lim)) begin
                    w_state_nxt   = ST_ATTRACT;
                    w_restart_req = 1'b1;
                end
            end
            ST_PLAY: begin
                w_jump_nxt = w_h_up;
                w_duck_nxt = w_h_dn & ~w_h_up;
                if (crash) begin
                    w_state_nxt = ST_DEAD;
                end
            end
            ST_DEAD: begin
                if (w_h_edge && (w_cnt >= c_lock_lim)) begin
                    w_state_nxt   = ST_PLAY;
                    w_restart_req = 1'b1;
                end else if (!w_h_act && (w_cnt >= c_idle_lim)) begin
                    w_state_nxt   = ST_ATTRACT;
                    w_restart_req = 1'b1;
                end
            end
            ST_ATTRACT: begin
                w_jump_nxt = ai_up & ~crash;
                if (w_h_edge) begin
                    w_state_nxt   = ST_PLAY;
                    w_restart_req = 1'b1;
                end else if (crash && (w_cnt >= c_restart_lim)) begin
                    w_restart_req = 1'b1;
                    w_cnt_rearm   = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // A pulse in the previous cycle has already cleared the game, so a
        // back-to-back request still changes mode but emits no second pulse.
        w_restart_nxt = w_restart_req & ~r_restart;

        // In ATTRACT the counter only measures time spent crashed; in IDLE
        // and DEAD any human activity restarts the inactivity window.
        w_cnt_clear = (w_state_nxt != r_state) | w_cnt_rearm
                    | (((r_state == ST_IDLE) | (r_state == ST_DEAD)) & w_h_act)
                    | ((r_state == ST_ATTRACT) & ~crash);
    end

    // State and registered outputs; reset also drops any pending restart
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_h_up_prev <= 1'b0;
            r_jump      <= 1'b0;
            r_duck      <= 1'b0;
            r_restart   <= 1'b0;
            r_autopilot <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_h_up_prev <= w_h_up;
            r_jump      <= w_jump_nxt;
            r_duck      <= w_duck_nxt;
            r_restart   <= w_restart_nxt;
            r_autopilot <= (w_state_nxt == ST_ATTRACT);
        end
    end

    assign jump_out      = r_jump;
    assign duck_out      = r_duck;
    assign restart_pulse = r_restart;
    assign autopilot     = r_autopilot;
    assign game_state    = r_state;

endmodule : input_mode_sequencer
`default_nettype wire
